// File: rtl/fifo_burst_reader.sv
// Drain stage for the synchronous FIFO: issues read enables, absorbs the
// one-cycle read latency in a 2-entry buffer and frames the words into
// valid/ready packets of BURST words, or single-word packets on timeout.
module fifo_burst_reader #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned BURST      = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  o_fifo_r_en,
  input  logic [WORD_WIDTH-1:0] i_fifo_r_data,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_aempty,
  output logic [WORD_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_last,
  output logic                  o_busy
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW   = $clog2(BURST + 1);
  localparam logic [TimerW-1:0] TimerMax   = TimerW'(TIMEOUT);
  localparam logic [CntW-1:0]   BurstLimit = CntW'(BURST);

  typedef enum logic [1:0] {StIdle, StBurst, StFlush} state_e;

  state_e                          state_q, state_d;
  logic [TimerW-1:0]               timer_q, timer_d;
  logic [CntW-1:0]                 issued_q, issued_d;
  logic [1:0][WORD_WIDTH-1:0]      buf_data_q, buf_data_d;
  logic [1:0]                      buf_last_q, buf_last_d;
  logic [1:0]                      occ_q, occ_d;
  logic                            inflight_q, inflight_last_q;

  logic [CntW-1:0] limit;
  logic            pop;
  logic [2:0]      occ_net;
  logic            rd_en;
  logic            last_now;
  logic [1:0]      wr_pos;

  // Read issue: only when the buffer is guaranteed room for the returning word.
  always_comb begin
    limit    = (state_q == StFlush) ? CntW'(1) : BurstLimit;
    pop      = o_m_valid && i_m_ready;
    occ_net  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en    = (state_q != StIdle) && !i_fifo_empty && (issued_q < limit) && (occ_net < 3'd2);
    last_now = (issued_q == limit - CntW'(1));
  end

  assign o_fifo_r_en = rd_en;

  // Next-state logic: idle timer, burst/flush entry, and return after the final read.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    issued_d = issued_q;
    case (state_q)
      StIdle: begin
        if (i_fifo_empty) begin
          timer_d = '0;
        end else if (i_fifo_aempty && (timer_q != TimerMax)) begin
          timer_d = timer_q + TimerW'(1);
        end
        // Burst wins over flush when both conditions hold.
        if (!i_fifo_aempty) begin
          state_d  = StBurst;
          issued_d = '0;
          timer_d  = '0;
        end else if ((timer_q == TimerMax) && !i_fifo_empty) begin
          state_d  = StFlush;
          issued_d = '0;
          timer_d  = '0;
        end
      end
      StBurst, StFlush: begin
        if (rd_en) begin
          issued_d = issued_q + CntW'(1);
          if (last_now) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output buffer: entry 0 is the head; pop shifts, returning data lands at the tail.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    wr_pos     = occ_q - {1'b0, pop};
    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
    end
    if (inflight_q) begin
      buf_data_d[wr_pos[0]] = i_fifo_r_data;
      buf_last_d[wr_pos[0]] = inflight_last_q;
    end
    occ_d = occ_net[1:0];
  end

  // State registers; a word still in flight at reset is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      timer_q         <= '0;
      issued_q        <= '0;
      buf_data_q      <= '0;
      buf_last_q      <= '0;
      occ_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      issued_q        <= issued_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
      occ_q           <= occ_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && last_now;
    end
  end

  // Stream outputs straight from the buffer head.
  always_comb begin
    o_m_valid = (occ_q != 2'd0);
    o_m_data  = buf_data_q[0];
    o_m_last  = buf_last_q[0];
    o_busy    = (state_q != StIdle) || (occ_q != 2'd0) || inflight_q;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO model plus an expected-word
// scoreboard filled whenever words are written into the model.
module tb_fifo_burst_reader;

  localparam int W       = 8;
  localparam int BURST   = 16;
  localparam int TIMEOUT = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         r_en;
  logic [W-1:0] fifo_rdata = '0;
  logic         fifo_empty, fifo_aempty;
  logic [W-1:0] m_data;
  logic         m_valid, m_last, busy;
  logic         i_m_ready;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_burst_reader #(.WORD_WIDTH(W), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .o_fifo_r_en  (r_en),
    .i_fifo_r_data(fifo_rdata),
    .i_fifo_empty (fifo_empty),
    .i_fifo_aempty(fifo_aempty),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .i_m_ready    (i_m_ready),
    .o_m_last     (m_last),
    .o_busy       (busy)
  );

  // FIFO model: pointers only, word k holds word_of(k); registered read data.
  int wr_ptr = 0, rd_ptr = 0, wr_cnt = 0, level = 16, fifo_count;
  always_comb fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty  = (fifo_count == 0);
  assign fifo_aempty = (fifo_count <= level);

  function automatic logic [W-1:0] word_of(input int k);
    return W'(k * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (wr_cnt > 0) wr_ptr <= wr_ptr + wr_cnt;
    if (r_en && !fifo_empty) begin
      fifo_rdata <= word_of(rd_ptr);
      rd_ptr     <= rd_ptr + 1;
    end
    // The FIFO shares the reset and is emptied by it.
    if (reset) rd_ptr <= wr_ptr;
  end

  typedef struct packed {logic [W-1:0] data; logic last;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  int n_total = 0, n_pass = 0;

  logic         s_hs, s_v, s_l, s_ren, s_emp, s_busy;
  logic [W-1:0] s_d;
  int           s_cyc;
  int           last_hs_cyc;

  task automatic step(input logic rdy);
    i_m_ready = rdy;
    @(negedge clk);
    s_v    = m_valid;
    s_hs   = m_valid && rdy;
    s_d    = m_data;
    s_l    = m_last;
    s_ren  = r_en;
    s_emp  = fifo_empty;
    s_busy = busy;
    s_cyc  = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n);
    i_m_ready = 1'b0;
    wr_cnt    = n;
    @(posedge clk);
    #1;
    wr_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total += 5;
    if (r_en !== 1'b0)   $display("FAIL reset_r_en: got %b want 0", r_en);   else n_pass++;
    if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else n_pass++;
    if (m_data !== '0)   $display("FAIL reset_data: got %h want 00", m_data); else n_pass++;
    if (m_last !== 1'b0) $display("FAIL reset_last: got %b want 0", m_last); else n_pass++;
    if (busy !== 1'b0)   $display("FAIL reset_busy: got %b want 0", busy);   else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int t = 0; t < 3; t++) step(1'b1);
    n_total++;
    if (s_v !== 1'b0 || s_busy !== 1'b0)
      $display("FAIL reset_idle: got valid %b busy %b want 0 0", s_v, s_busy);
    else n_pass++;
  endtask

  task automatic test_burst();
    int base, c0, got, first;
    base = wr_ptr;
    for (int i = 0; i < 20; i++) exp_q.push_back('{word_of(base + i), (i == 15) || (i >= 16)});
    push_words(20);
    c0 = cyc; got = 0; first = -1;
    for (int t = 0; t < 100 && got < 16; t++) begin
      step(1'b1);
      if (s_hs) begin
        if (first < 0) first = s_cyc;
        last_hs_cyc = s_cyc;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL burst_word: unexpected word %h", s_d);
        else begin
          e = exp_q.pop_front();
          if (s_d !== e.data || s_l !== e.last)
            $display("FAIL burst_word %0d: got %h/%b want %h/%b", got, s_d, s_l, e.data, e.last);
          else n_pass++;
        end
        got++;
      end
    end
    n_total += 4;
    if (got !== 16) $display("FAIL burst_count: got %0d want 16", got); else n_pass++;
    if (first - c0 !== 3) $display("FAIL burst_latency: got %0d want 3", first - c0); else n_pass++;
    if (last_hs_cyc - first !== 15)
      $display("FAIL burst_rate: got %0d cycles want 15", last_hs_cyc - first);
    else n_pass++;
    if (fifo_count !== 4) $display("FAIL burst_left: got %0d want 4", fifo_count); else n_pass++;
  endtask

  task automatic test_flush();
    int got;
    got = 0;
    for (int t = 0; t < 1300 && got < 4; t++) begin
      step(1'b1);
      if (s_hs) begin
        n_total += 2;
        if (s_cyc - last_hs_cyc < TIMEOUT)
          $display("FAIL flush_gap: got %0d cycles want >= %0d", s_cyc - last_hs_cyc, TIMEOUT);
        else n_pass++;
        last_hs_cyc = s_cyc;
        if (exp_q.size() == 0) $display("FAIL flush_word: unexpected word %h", s_d);
        else begin
          e = exp_q.pop_front();
          if (s_d !== e.data || s_l !== e.last)
            $display("FAIL flush_word %0d: got %h/%b want %h/%b", got, s_d, s_l, e.data, e.last);
          else n_pass++;
        end
        got++;
      end
    end
    for (int t = 0; t < 3; t++) step(1'b1);
    n_total += 3;
    if (got !== 4) $display("FAIL flush_count: got %0d want 4", got); else n_pass++;
    if (fifo_count !== 0) $display("FAIL flush_fifo: got %0d want 0", fifo_count); else n_pass++;
    if (s_busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", s_busy); else n_pass++;
  endtask

  task automatic test_toggle();
    int base, got, outstanding, v_occ, v_stab, v_emp;
    logic         stalled, pl;
    logic [W-1:0] pd;
    base = wr_ptr;
    for (int i = 0; i < 17; i++) exp_q.push_back('{word_of(base + i), (i >= 15)});
    push_words(17);
    got = 0; outstanding = 0; v_occ = 0; v_stab = 0; v_emp = 0; stalled = 1'b0;
    pd = '0; pl = 1'b0;
    for (int t = 0; t < 1000 && got < 17; t++) begin
      step((t % 2) == 0);
      if (s_ren && s_emp) v_emp++;
      if (stalled && (!s_v || s_d !== pd || s_l !== pl)) v_stab++;
      stalled = s_v && !s_hs; pd = s_d; pl = s_l;
      outstanding = outstanding + int'(s_ren && !s_emp) - int'(s_hs);
      if (outstanding > 2) v_occ++;
      if (s_hs) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL toggle_word: unexpected word %h", s_d);
        else begin
          e = exp_q.pop_front();
          if (s_d !== e.data || s_l !== e.last)
            $display("FAIL toggle_word %0d: got %h/%b want %h/%b", got, s_d, s_l, e.data, e.last);
          else n_pass++;
        end
        got++;
      end
    end
    n_total += 4;
    if (got !== 17) $display("FAIL toggle_count: got %0d want 17", got); else n_pass++;
    if (v_occ !== 0) $display("FAIL toggle_occupancy: got %0d overflows want 0", v_occ); else n_pass++;
    if (v_stab !== 0) $display("FAIL toggle_stable: got %0d changes want 0", v_stab); else n_pass++;
    if (v_emp !== 0) $display("FAIL toggle_ren_empty: got %0d want 0", v_emp); else n_pass++;
  endtask

  task automatic test_stall();
    int base, got, v_emp, extra;
    level = 0;
    base  = wr_ptr;
    for (int i = 0; i < 16; i++) exp_q.push_back('{word_of(base + i), (i == 15)});
    push_words(1);
    got = 0; v_emp = 0; extra = 0;
    for (int t = 0; t < 200 && got < 16; t++) begin
      if (t == 9) push_words(15);
      step(1'b1);
      if (s_ren && s_emp) v_emp++;
      if (s_hs) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL stall_word: unexpected word %h", s_d);
        else begin
          e = exp_q.pop_front();
          if (s_d !== e.data || s_l !== e.last)
            $display("FAIL stall_word %0d: got %h/%b want %h/%b", got, s_d, s_l, e.data, e.last);
          else n_pass++;
        end
        got++;
      end
    end
    for (int t = 0; t < 5; t++) begin
      step(1'b1);
      if (s_hs) extra++;
    end
    level = 16;
    n_total += 3;
    if (got !== 16) $display("FAIL stall_count: got %0d want 16", got); else n_pass++;
    if (v_emp !== 0) $display("FAIL stall_ren_empty: got %0d want 0", v_emp); else n_pass++;
    if (extra !== 0) $display("FAIL stall_extra: got %0d words want 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base, got, stale;
    base = wr_ptr;
    for (int i = 0; i < 20; i++) exp_q.push_back('{word_of(base + i), (i == 15) || (i >= 16)});
    push_words(20);
    got = 0;
    for (int t = 0; t < 50 && got < 4; t++) begin
      step(1'b1);
      if (s_hs) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL rstmid_word: unexpected word %h", s_d);
        else begin
          e = exp_q.pop_front();
          if (s_d !== e.data || s_l !== e.last)
            $display("FAIL rstmid_word %0d: got %h/%b want %h/%b", got, s_d, s_l, e.data, e.last);
          else n_pass++;
        end
        got++;
      end
    end
    reset = 1'b1;
    step(1'b1);
    @(negedge clk);
    n_total += 5;
    if (r_en !== 1'b0)    $display("FAIL rstmid_r_en: got %b want 0", r_en);    else n_pass++;
    if (m_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", m_valid); else n_pass++;
    if (m_data !== '0)    $display("FAIL rstmid_data: got %h want 00", m_data); else n_pass++;
    if (m_last !== 1'b0)  $display("FAIL rstmid_last: got %b want 0", m_last);  else n_pass++;
    if (busy !== 1'b0)    $display("FAIL rstmid_busy: got %b want 0", busy);    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    stale = 0;
    for (int t = 0; t < 6; t++) begin
      step(1'b1);
      if (s_v) stale++;
    end
    n_total += 2;
    if (got !== 4) $display("FAIL rstmid_count: got %0d want 4", got); else n_pass++;
    if (stale !== 0) $display("FAIL rstmid_stale: got %0d valid cycles want 0", stale); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base, got, prev, maxgap;
    base = wr_ptr;
    for (int i = 0; i < 40; i++)
      exp_q.push_back('{word_of(base + i), (i >= 32) || ((i % 16) == 15)});
    push_words(40);
    got = 0; prev = 0; maxgap = 0;
    for (int t = 0; t < 2600 && got < 40; t++) begin
      step(1'b1);
      if (s_hs) begin
        if (got > 0 && got < 32 && (s_cyc - prev - 1) > maxgap) maxgap = s_cyc - prev - 1;
        prev = s_cyc;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_word: unexpected word %h", s_d);
        else begin
          e = exp_q.pop_front();
          if (s_d !== e.data || s_l !== e.last)
            $display("FAIL b2b_word %0d: got %h/%b want %h/%b", got, s_d, s_l, e.data, e.last);
          else n_pass++;
        end
        got++;
      end
    end
    n_total += 3;
    if (got !== 40) $display("FAIL b2b_count: got %0d want 40", got); else n_pass++;
    if (maxgap > 1) $display("FAIL b2b_gap: got %0d idle cycles want <= 1", maxgap); else n_pass++;
    if (exp_q.size() !== 0) $display("FAIL b2b_left: got %0d pending want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    reset     = 1'b1;
    i_m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_burst();
    test_flush();
    test_toggle();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
